// File: rtl/timer_pkg.sv
// Shared constants for the timer counter read/compare block.
//   - Register byte offsets for the counter, compare, enable and status registers.
//   - Compare register reset value (CMP_RST).
//   - Bit positions of the interrupt enable (TIER) and status (TISR) flags.
package timer_pkg;

  localparam int unsigned TDR0_OFFSET  = 32'h0000_000C;  // counter low word, read-only
  localparam int unsigned TDR1_OFFSET  = 32'h0000_0010;  // counter high word, read-only
  localparam int unsigned TCMP0_OFFSET = 32'h0000_0014;  // compare low word
  localparam int unsigned TCMP1_OFFSET = 32'h0000_0018;  // compare high word
  localparam int unsigned TIER_OFFSET  = 32'h0000_001C;  // interrupt enable
  localparam int unsigned TISR_OFFSET  = 32'h0000_0020;  // interrupt status, W1C

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int unsigned TIER_EN_BIT = 0;
  localparam int unsigned TISR_ST_BIT = 0;

endpackage

// File: rtl/timer_cmp_match.sv
// Compare register and sticky match status for the timer counter.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   cnt_i        live counter value
//   tcmp_lo_we_i write strobe for the compare low word
//   tcmp_hi_we_i write strobe for the compare high word
//   wdata_i      write data for either compare word
//   st_clr_i     clear request for the sticky status (W1C decoded upstream)
//   tcmp_o       current compare value
//   int_st_o     sticky compare-match status
module timer_cmp_match import timer_pkg::*; #(
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      CNT_W   = 2 * DATA_W,
  parameter logic [CNT_W-1:0] CMP_RST = timer_pkg::CMP_RST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              tcmp_lo_we_i,
  input  logic              tcmp_hi_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              st_clr_i,
  output logic [CNT_W-1:0]  tcmp_o,
  output logic              int_st_o
);

  logic [CNT_W-1:0] tcmp_q, tcmp_d;
  logic             match;
  logic             match_q;
  logic             int_st_q, int_st_d;

  always_comb begin
    tcmp_d = tcmp_q;
    if (tcmp_lo_we_i) tcmp_d[DATA_W-1:0]     = wdata_i;
    if (tcmp_hi_we_i) tcmp_d[CNT_W-1:DATA_W] = wdata_i;
  end

  assign match = (cnt_i == tcmp_q);

  // Edge-triggered set so a counter parked on tcmp fires once; a set beats a clear.
  assign int_st_d = (match & ~match_q) | (int_st_q & ~st_clr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      tcmp_q   <= CMP_RST;
      match_q  <= 1'b0;
      int_st_q <= 1'b0;
    end else begin
      tcmp_q   <= tcmp_d;
      match_q  <= match;
      int_st_q <= int_st_d;
    end
  end

  assign tcmp_o   = tcmp_q;
  assign int_st_o = int_st_q;

endmodule

// File: rtl/timer_cnt_reader.sv
// Read/compare side of the 64-bit timer counter: register read port for the live counter,
// compare register, interrupt enable and sticky match status. Never writes the counter.
// Ports:
//   clk      clock
//   rst      synchronous reset, active-high
//   rd_en    register read strobe, one cycle per access
//   wr_en    register write strobe, one cycle per access
//   addr     register byte address
//   wdata    write data
//   cnt      live counter value
//   rdata    read data, valid when rvalid=1 (zero otherwise)
//   rvalid   read response strobe, one cycle after rd_en
//   int_st   sticky compare-match status
//   tim_int  interrupt = int_st & int_en
// Build option: define TMR_RD_SNAPSHOT_EN to latch cnt[63:32] on a TDR0 read so the following
// TDR1 read returns a value coherent with the low word.
module timer_cnt_reader import timer_pkg::*; #(
  parameter int unsigned      ADDR_W  = 12,
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      CNT_W   = 2 * DATA_W,
  parameter logic [CNT_W-1:0] CMP_RST = timer_pkg::CMP_RST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              int_st,
  output logic              tim_int
);

  logic hit_tdr0, hit_tdr1, hit_tcmp0, hit_tcmp1, hit_tier, hit_tisr;

  assign hit_tdr0  = (addr == ADDR_W'(TDR0_OFFSET));
  assign hit_tdr1  = (addr == ADDR_W'(TDR1_OFFSET));
  assign hit_tcmp0 = (addr == ADDR_W'(TCMP0_OFFSET));
  assign hit_tcmp1 = (addr == ADDR_W'(TCMP1_OFFSET));
  assign hit_tier  = (addr == ADDR_W'(TIER_OFFSET));
  assign hit_tisr  = (addr == ADDR_W'(TISR_OFFSET));

  logic [CNT_W-1:0] tcmp;
  logic             int_st_w;
  logic             st_clr;

  assign st_clr = wr_en & hit_tisr & wdata[TISR_ST_BIT];

  timer_cmp_match #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .CMP_RST (CMP_RST)
  ) u_cmp_match (
    .clk          (clk),
    .rst          (rst),
    .cnt_i        (cnt),
    .tcmp_lo_we_i (wr_en & hit_tcmp0),
    .tcmp_hi_we_i (wr_en & hit_tcmp1),
    .wdata_i      (wdata),
    .st_clr_i     (st_clr),
    .tcmp_o       (tcmp),
    .int_st_o     (int_st_w)
  );

  logic int_en_q, int_en_d;

  assign int_en_d = (wr_en & hit_tier) ? wdata[TIER_EN_BIT] : int_en_q;

  // High counter word as seen by a TDR1 read.
  logic [DATA_W-1:0] tdr1_val;

`ifdef TMR_RD_SNAPSHOT_EN
  logic [DATA_W-1:0] shadow_q;
  logic              snap_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      snap_vld_q <= 1'b0;
    end else if (rd_en && hit_tdr0) begin
      shadow_q   <= cnt[CNT_W-1:DATA_W];
      snap_vld_q <= 1'b1;
    end else if (rd_en && hit_tdr1) begin
      snap_vld_q <= 1'b0;
    end
  end

  assign tdr1_val = snap_vld_q ? shadow_q : cnt[CNT_W-1:DATA_W];
`else
  assign tdr1_val = cnt[CNT_W-1:DATA_W];
`endif

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  // Read mux; unmapped addresses and idle cycles return zero.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      if (hit_tdr0)       rdata_d = cnt[DATA_W-1:0];
      else if (hit_tdr1)  rdata_d = tdr1_val;
      else if (hit_tcmp0) rdata_d = tcmp[DATA_W-1:0];
      else if (hit_tcmp1) rdata_d = tcmp[CNT_W-1:DATA_W];
      else if (hit_tier)  rdata_d[TIER_EN_BIT] = int_en_q;
      else if (hit_tisr)  rdata_d[TISR_ST_BIT] = int_st_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      int_en_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_en;
      int_en_q <= int_en_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign int_st  = int_st_w;
  assign tim_int = int_st_w & int_en_q;

endmodule

// File: tb/tb_timer_cnt_reader.sv
module tb_timer_cnt_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [63:0] cnt;
  logic [31:0] rdata;
  logic        rvalid;
  logic        int_st;
  logic        tim_int;

  always #5 clk = ~clk;

  timer_cnt_reader u_dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .cnt     (cnt),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .int_st  (int_st),
    .tim_int (tim_int)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept as plain register-map values.
  logic [63:0] m_tcmp;
  logic        m_en;
  logic        m_st;
  logic        m_prev;
  logic [31:0] m_shadow;
  logic        m_snap;
  logic [31:0] e_rdata;
  logic        e_rvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h00C: return cnt[31:0];
`ifdef TMR_RD_SNAPSHOT_EN
      12'h010: return m_snap ? m_shadow : cnt[63:32];
`else
      12'h010: return cnt[63:32];
`endif
      12'h014: return m_tcmp[31:0];
      12'h018: return m_tcmp[63:32];
      12'h01C: return {31'b0, m_en};
      12'h020: return {31'b0, m_st};
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock with the inputs currently driven, update the model, then compare.
  task automatic cycle();
    logic match_now, rise, clr;
    if (rst) begin
      m_tcmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 0; m_st = 0; m_prev = 0;
      m_shadow = 0; m_snap = 0; e_rvalid = 0; e_rdata = 0;
    end else begin
      match_now = (cnt == m_tcmp);
      rise      = match_now && !m_prev;
      e_rvalid  = rd_en;
      e_rdata   = rd_en ? model_read(addr) : 32'h0;
      if (rd_en && addr == 12'h00C) begin
        m_shadow = cnt[63:32];
        m_snap   = 1'b1;
      end else if (rd_en && addr == 12'h010) begin
        m_snap = 1'b0;
      end
      clr = wr_en && addr == 12'h020 && wdata[0];
      if (rise) m_st = 1'b1;
      else if (clr) m_st = 1'b0;
      if (wr_en && addr == 12'h014) m_tcmp[31:0]  = wdata;
      if (wr_en && addr == 12'h018) m_tcmp[63:32] = wdata;
      if (wr_en && addr == 12'h01C) m_en = wdata[0];
      m_prev = match_now;
    end
    @(posedge clk);
    #1;
    chk("rvalid", {31'b0, rvalid}, {31'b0, e_rvalid});
    if (e_rvalid || rst) chk("rdata", rdata, e_rdata);
    chk("int_st", {31'b0, int_st}, {31'b0, m_st});
    chk("tim_int", {31'b0, tim_int}, {31'b0, m_st & m_en});
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0;
    cycle();
  endtask

  task automatic rd(input logic [11:0] a);
    rd_en = 1; wr_en = 0; addr = a;
    cycle();
    rd_en = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    rd_en = 0; wr_en = 1; addr = a; wdata = d;
    cycle();
    wr_en = 0;
  endtask

  logic [11:0] addr_tbl [8] = '{12'h00C, 12'h010, 12'h014, 12'h018,
                                12'h01C, 12'h020, 12'h040, 12'h000};

  initial begin
    rst = 1; rd_en = 0; wr_en = 0; addr = 0; wdata = 0; cnt = 0;
    cycle();
    rst = 0;

    // Reset values through the read port.
    rd(12'h014); chk("rst_tcmp0", rdata, 32'hFFFF_FFFF);
    rd(12'h018); chk("rst_tcmp1", rdata, 32'hFFFF_FFFF);
    rd(12'h01C); chk("rst_tier", rdata, 32'h0);
    rd(12'h020); chk("rst_tisr", rdata, 32'h0);
    idle();      chk("rvalid_one_cycle", {31'b0, rvalid}, 32'h0);

    // Compare match on a ramping counter.
    wr(12'h014, 32'h10);
    wr(12'h018, 32'h0);
    wr(12'h01C, 32'h1);
    for (int v = 'h0E; v <= 'h12; v++) begin
      cnt = 64'(v);
      idle();
      if (v == 'h0F) chk("pre_match_st", {31'b0, int_st}, 32'h0);
      if (v == 'h10) begin
        chk("match_st", {31'b0, int_st}, 32'h1);
        chk("match_int", {31'b0, tim_int}, 32'h1);
      end
    end
    wr(12'h020, 32'h0); chk("w0_tisr_noop", {31'b0, int_st}, 32'h1);
    wr(12'h020, 32'h1);
    chk("w1c_st", {31'b0, int_st}, 32'h0);
    chk("w1c_int", {31'b0, tim_int}, 32'h0);

    // Halted counter on tcmp fires only once; set wins over a same-cycle clear.
    cnt = 64'h10;
    idle();  chk("hold_edge", {31'b0, int_st}, 32'h1);
    wr(12'h020, 32'h1);
    idle();
    idle();  chk("hold_no_refire", {31'b0, int_st}, 32'h0);
    cnt = 64'h11; idle();
    cnt = 64'h10;
    wr(12'h020, 32'h1); chk("set_beats_clr", {31'b0, int_st}, 32'h1);

    // A compare write that lands on the live counter is a new edge.
    wr(12'h020, 32'h1);
    cnt = 64'h55;
    wr(12'h014, 32'h55);
    idle();  chk("tcmp_wr_edge", {31'b0, int_st}, 32'h1);

    // Coherent 64-bit read across a carry.
    cnt = 64'h0000_0000_FFFF_FFFF;
    rd(12'h00C); chk("snap_tdr0", rdata, 32'hFFFF_FFFF);
    cnt = 64'h0000_0001_0000_0000;
    idle();
    rd(12'h010);
`ifdef TMR_RD_SNAPSHOT_EN
    chk("snap_tdr1", rdata, 32'h0000_0000);
`else
    chk("snap_tdr1", rdata, 32'h0000_0001);
`endif

    // Counter registers are read-only here; unmapped reads return zero.
    cnt = 64'h0000_00AB_0000_00CD;
    wr(12'h00C, 32'h1234);
    wr(12'h010, 32'h5678);
    rd(12'h00C); chk("tdr0_ro", rdata, 32'h0000_00CD);
    rd(12'h010); chk("tdr1_ro", rdata, 32'h0000_00AB);
    rd(12'h040); chk("unmapped", rdata, 32'h0);
    rd_en = 1; wr_en = 1; addr = 12'h01C; wdata = 32'h0;
    cycle(); chk("rd_wr_same", rdata, 32'h1);
    rd_en = 0; wr_en = 0;
    rd(12'h01C); chk("rd_after_wr", rdata, 32'h0);

    // Reset one cycle after a read drops the pending response.
    rd(12'h014);
    rst = 1;
    cycle();
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_int_st", {31'b0, int_st}, 32'h0);
    rst = 0;

    // Wrap-around with the default compare value matches once at the max.
    cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    idle();  chk("wrap_match", {31'b0, int_st}, 32'h1);
    cnt = 64'h0;
    wr(12'h020, 32'h1);
    cnt = 64'h1;
    idle();  chk("wrap_no_refire", {31'b0, int_st}, 32'h0);

    // Randomised traffic against the model.
    rst = 1; cycle(); rst = 0;
    cnt = 64'(32'($urandom_range(0, 40)));
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      rd_en = $urandom_range(0, 1) == 1;
      wr_en = $urandom_range(0, 2) == 0;
      addr  = addr_tbl[$urandom_range(0, 7)];
      if (addr == 12'h018) wdata = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0;
      else if ($urandom_range(0, 3) == 0) wdata = $urandom;
      else wdata = 32'($urandom_range(0, 64));
      case ($urandom_range(0, 9))
        0:       cnt = m_tcmp - 64'd2;
        1:       cnt = {32'($urandom_range(0, 1)), $urandom};
        2:       cnt = cnt;
        3:       cnt = 64'(32'($urandom_range(0, 64)));
        default: cnt = cnt + 64'd1;
      endcase
      cycle();
    end
    rst = 0; rd_en = 0; wr_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
